traffic_interval_timer: RTL

Interval-timer and car-sensor front end serving the traffic-light controller. It is the responder to the controller's timer-initialise request: it receives `IC`, times the short and long phase intervals, and returns the `S` (short expired) and `L` (long expired) flags. It also synchronises the raw car-detector input and returns it as the clean `C` flag. It sits between board I/O and the controller's `S`, `L` and `C` inputs, all on the same clock.

---
 rtl/traffic_interval_timer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/traffic_interval_timer.sv
// traffic_interval_timer
//   Interval timer and car-sensor front end for the traffic-light controller.
//   The timer restarts on IC (or R) and reports short (S) and long (L)
//   interval expiry. The raw car detector is synchronised (and optionally
//   debounced) to produce the clean car-present flag C.
//
// Configuration macro:
//   TIMER_DEBOUNCE_EN - when defined, C only changes after the synchronised
//                       car input has held a new value for DEBOUNCE_CYCLES
//                       consecutive cycles. When undefined, C is a plain third
//                       flop after the synchroniser (fixed 3-edge latency).
//
// Ports:
//   clk      in   system clock, rising edge
//   R        in   synchronous active-high reset (timer and car path)
//   IC       in   initialise counter: restart the interval timer
//   car_raw  in   asynchronous raw car-detector input
//   S        out  short interval expired (registered level)
//   L        out  long interval expired (registered level)
//   C        out  car present, synchronised / debounced (registered)

module traffic_interval_timer #(
  parameter int SHORT_CYCLES    = 4,
  parameter int LONG_CYCLES     = 10,
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic clk,
  input  logic R,
  input  logic IC,
  input  logic car_raw,
  output logic S,
  output logic L,
  output logic C
);

  // Elaboration-time parameter sanity.
  if (SHORT_CYCLES < 1 || SHORT_CYCLES >= LONG_CYCLES ||
      64'(LONG_CYCLES) >= (64'd1 << CNT_W) || DEBOUNCE_CYCLES < 1) begin : g_param_err
    $error("traffic_interval_timer: illegal parameter combination");
  end

  localparam logic [CNT_W-1:0] SHORT_TH = CNT_W'(SHORT_CYCLES);
  localparam logic [CNT_W-1:0] LONG_TH  = CNT_W'(LONG_CYCLES);

  // Encoding chosen so S = state[0] and L = state[1]: both flags come
  // straight off state flops with no decode glitches.
  typedef enum logic [1:0] {
    RUN_SHORT = 2'b00,
    RUN_LONG  = 2'b01,
    EXPIRED   = 2'b11
  } tstate_t;

  tstate_t          state;
  tstate_t          state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;

  // State register
  always_ff @(posedge clk) begin
    if (R) begin
      state <= RUN_SHORT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; IC overrides any threshold reached in the same cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cnt_inc   = cnt + 1'b1;
    if (IC) begin
      state_nxt = RUN_SHORT;
      cnt_nxt   = '0;
    end else begin
      case (state)
        RUN_SHORT: begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == SHORT_TH) state_nxt = RUN_LONG;
        end
        RUN_LONG: begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == LONG_TH) state_nxt = EXPIRED;
        end
        EXPIRED: begin
          // Counter saturates at LONG_CYCLES.
          cnt_nxt = cnt;
        end
        default: begin
          state_nxt = RUN_SHORT;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Output logic
  always_comb begin
    S = state[0];
    L = state[1];
  end

  // Car path: two-flop synchroniser.
  logic s1;
  logic s2;
  logic c_q;

  always_ff @(posedge clk) begin
    if (R) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= car_raw;
      s2 <= s1;
    end
  end

`ifdef TIMER_DEBOUNCE_EN
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [DB_W-1:0] db_cnt;

  // db_cnt counts consecutive cycles s2 has disagreed with C; any agreement
  // clears it, so a pulse shorter than DEBOUNCE_CYCLES never reaches C.
  always_ff @(posedge clk) begin
    if (R) begin
      db_cnt <= '0;
      c_q    <= 1'b0;
    end else if (s2 == c_q) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      c_q    <= s2;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (R) c_q <= 1'b0;
    else   c_q <= s2;
  end
`endif

  assign C = c_q;

endmodule
